// File: rtl/enabled_register_reader.sv
// -----------------------------------------------------------------------------
// enabled_register_reader
//
// Purpose:
//   This block is the read-side companion to an enabled-register write path.
//   The upstream writer has no backpressure. It drives enable/data_in exactly
//   as it would drive an enabled register. Every enabled word is captured into
//   a small in-order buffer. The buffer is presented to a downstream consumer
//   over a valid/ready handshake with first-word fall-through. A write that
//   finds the buffer full (and no simultaneous pop) is dropped, and a sticky
//   overflow flag records it.
//
// Parameters:
//   WIDTH  data word width in bits (default 4)
//   DEPTH  buffer entries, power of 2 and >= 2 (default 4)
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   write strobe, one word offered per cycle while high
//   data_in       in   write data, sampled when enable is high
//   rd_valid      out  buffer non-empty, rd_data is meaningful
//   rd_ready      in   consumer accepts rd_data this cycle
//   rd_data       out  oldest buffered word (stale/reset data when empty)
//   overflow      out  sticky, a write was dropped
//   clr_overflow  in   clears overflow (a same-cycle drop takes priority)
//   level         out  occupancy 0..DEPTH, only with ENREG_READER_LEVEL_EN
//
// Configuration macro:
//   ENREG_READER_LEVEL_EN  when defined, exposes the occupancy count on the
//                          level port. Otherwise the port is absent and the
//                          behaviour is unchanged.
// -----------------------------------------------------------------------------
module enabled_register_reader #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef ENREG_READER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // Storage and bookkeeping registers
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    // Per-cycle handshake decode
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [DEPTH-1:0] w_we;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && rd_ready;
    // A pop in the same cycle frees the slot the write needs. This is how a
    // full buffer still accepts a write while it is being drained.
    assign w_push  = enable && (!w_full || w_pop);
    assign w_drop  = enable && w_full && !w_pop;

    // One-hot write enable per storage entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push && (r_wr_ptr == PW'(gi));
        end
    endgenerate

    // Storage. Every entry is cleared on reset so that rd_data reads 0
    // after reset instead of showing leftovers from before the reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    // Pointers wrap modulo DEPTH through their natural width
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy. A push and a pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear wins, so a lost
    // word is never hidden by a clear that arrives at the same moment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // First-word fall-through read port
    assign rd_valid = !w_empty;
    assign rd_data  = r_mem[r_rd_ptr];
    assign overflow = r_overflow;

`ifdef ENREG_READER_LEVEL_EN
    assign level = r_count;
`endif

endmodule

// File: doc/enabled_register_reader.md
# enabled_register_reader

Read-side companion to the enabled-register write path. An upstream writer drives `enable`/`data_in` with no backpressure, exactly as it would drive an enabled register. This block captures every enabled word into a small in-order buffer and presents it to a downstream consumer over a valid/ready handshake. It sits between register-style producers and handshake-style consumers, and flags writes lost to a full buffer.

## Interface
Parameters:
- `WIDTH`, default 4: data word width in bits.
- `DEPTH`, default 4: buffer entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: write strobe; one word offered per cycle while high.
- `data_in` input WIDTH: write data, sampled when `enable` is high.
- `rd_valid` output 1: buffer non-empty; `rd_data` is valid.
- `rd_ready` input 1: consumer accepts `rd_data` this cycle.
- `rd_data` output WIDTH: oldest buffered word.
- `overflow` output 1: sticky; a write was dropped.
- `clr_overflow` input 1: clears `overflow`.
- `level` output $clog2(DEPTH)+1: occupancy. Present only when `ENREG_READER_LEVEL_EN` is defined.

Clock and reset are fixed: a single clock `clk`, with `reset_n` asynchronous and active-low.

## Operation
- Storage is DEPTH×WIDTH registers with a write pointer, a read pointer, and an occupancy count of range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Define `pop` = `rd_valid` && `rd_ready`.
- Define `push` = `enable` && (count < DEPTH || `pop`).
- Full-buffer exception: a write in the same cycle as a pop is accepted.
- On push: `mem[wr_ptr]` ← `data_in`, then `wr_ptr`++.
- On pop: `rd_ptr`++.
- Count update: push only → count+1; pop only → count−1; both or neither → unchanged.
- Drop: `enable` && count == DEPTH && !`pop`. The word is discarded, storage and pointers are untouched, and `overflow` is set.
- `overflow` clears on `clr_overflow`. If a drop and `clr_overflow` occur in the same cycle, set wins.
- `rd_valid` = (count != 0).
- `rd_data` = `mem[rd_ptr]`. This is combinational from registers, so the read path is first-word fall-through.
- When `rd_valid` is 0, `rd_data` shows `mem[rd_ptr]`, which is stale or reset data. Consumers must qualify with `rd_valid`.
- `rd_ready` while empty has no effect.
- `data_in` is ignored when `enable` is low.

## Timing
- Reset asserted (async, immediate): pointers 0, count 0, all `mem` entries 0, `rd_valid` 0, `rd_data` 0, `overflow` 0, `level` 0.
- Reset asserted mid-transfer discards all buffered data. No partial state survives.
- Reset deassertion is synchronous to `clk` by the system. The first write is accepted on the first rising edge with `reset_n` high.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible with `rd_valid` = 1 after edge N.
- A pop at edge N presents the next word, or `rd_valid` = 0, after edge N.
- Sustained throughput is one word per cycle when `enable` and `rd_ready` are both high continuously. Occupancy is constant.
- `overflow` rises the cycle after the dropping edge. It stays high until a `clr_overflow` edge with no simultaneous drop.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Configuration
- Macro: `ENREG_READER_LEVEL_EN`.
- Defined: the `level` output port exists and equals the internal count. It is registered, reset value 0, range 0..DEPTH, and updates on the same edge as push/pop.
- Undefined: the `level` port is absent. Internal count logic and all other behaviour are identical.

## Test plan
- Reset and idle: hold `reset_n` = 0, then release with `enable` = 0. Required: `rd_valid` = 0, `rd_data` = 0, `overflow` = 0, `level` = 0.
- Single word: `enable` for 1 cycle with `data_in` = 4'hA, `rd_ready` = 0. Required: `rd_valid` = 1 and `rd_data` = A the next cycle. Then `rd_ready` = 1 for 1 cycle. Required: `rd_valid` = 0.
- Fill and overflow: write 1, 2, 3, 4, 5 on consecutive cycles with `rd_ready` = 0.
  - Required: `level` = 4, `overflow` = 1 after the 5th write.
  - Then drain. Required: reads return 1, 2, 3, 4; 5 is lost.
  - Then `clr_overflow`. Required: `overflow` = 0.
- Full with simultaneous push/pop: with the buffer full of 1..4, assert `enable` with 9 and `rd_ready` together. Required: 1 is popped, 9 is accepted, `overflow` stays 0. The drain order is 2, 3, 4, 9.
- Streaming and wrap: run 20 cycles with `enable` = `rd_ready` = 1 and incrementing data 0..19. Required: output sequence 0..19 with one cycle of lag, `level` constant at 1, no overflow.
- Async reset mid-operation: assert `reset_n` = 0 between edges with the buffer holding 3 words. Required: `rd_valid` and `level` drop to 0 immediately, without waiting for a clock edge. After release, the first new write reads back correctly.
